// File: rtl/reg_file_pkg.sv
// Shared configuration for the register file and its operand resolvers.
// Holds the ROB tag width macro, register/data width constants and the
// operand source encoding used inside the resolver.
// Optional feature macro: REG_FILE_COMMIT_BYPASS_EN (see reg_operand_resolve).

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package reg_file_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    // Where a resolved operand value comes from, in priority order
    typedef enum logic [2:0] {
        SRC_ZERO   = 3'd0,
        SRC_REG    = 3'd1,
        SRC_BYPASS = 3'd2,
        SRC_ROB    = 3'd3,
        SRC_WAIT   = 3'd4
    } operand_src_e;

    // x0 is hardwired to zero and never renamed
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/reg_file_operand_resolve.sv
// Resolves one source operand from architectural state, an optional
// same-cycle commit bypass, and the ROB lookup result.
// Optional feature macro: REG_FILE_COMMIT_BYPASS_EN enables the commit bypass.

module reg_operand_resolve
    import reg_file_pkg::*;
#(
    parameter int ROB_W = `ROB_SIZE_WIDTH
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  busy,
    input  logic [ROB_W-1:0]      tag,
    input  logic [DATA_W-1:0]     reg_value,
    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [ROB_W-1:0]      commit_rob_id,
    input  logic [DATA_W-1:0]     commit_value,
    input  logic                  get_ready,
    input  logic [DATA_W-1:0]     get_value,
    output logic [DATA_W-1:0]     val,
    output logic                  ready,
    output logic [ROB_W-1:0]      dep
);

    operand_src_e src;
    logic         bypass_hit;

`ifdef REG_FILE_COMMIT_BYPASS_EN
    // A commit that is retiring exactly the producer we are waiting on
    assign bypass_hit = commit_valid && (commit_rd == rs) && (commit_rob_id == tag);
`else
    logic unused_bypass;
    assign unused_bypass = ^{commit_valid, commit_rd, commit_rob_id, commit_value};
    assign bypass_hit    = 1'b0;
`endif

    // Pick the highest-priority source that can supply the operand
    always_comb begin
        src = SRC_WAIT;
        if (is_x0(rs)) begin
            src = SRC_ZERO;
        end else if (!busy) begin
            src = SRC_REG;
        end else if (bypass_hit) begin
            src = SRC_BYPASS;
        end else if (get_ready) begin
            src = SRC_ROB;
        end
    end

    // Drive value/ready/dep from the selected source; dep only while waiting
    always_comb begin
        val   = '0;
        ready = 1'b1;
        dep   = '0;
        case (src)
            SRC_ZERO:   val = '0;
            SRC_REG:    val = reg_value;
`ifdef REG_FILE_COMMIT_BYPASS_EN
            SRC_BYPASS: val = commit_value;
`endif
            SRC_ROB:    val = get_value;
            default: begin
                val   = '0;
                ready = 1'b0;
                dep   = tag;
            end
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags for an out-of-order core.
// Tracks a value, busy bit and producing ROB tag per register, handles
// issue-side renaming, commit writeback and misprediction flush, and
// resolves two source operands for the decoder.
// Optional feature macro: REG_FILE_COMMIT_BYPASS_EN (commit-to-read bypass).

module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_W = `ROB_SIZE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [ROB_W-1:0]      issue_rob_id,
    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [ROB_W-1:0]      commit_rob_id,
    input  logic [DATA_W-1:0]     commit_value,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic [ROB_W-1:0]      get_rob_id1,
    output logic [ROB_W-1:0]      get_rob_id2,
    input  logic                  get_ready1,
    input  logic                  get_ready2,
    input  logic [DATA_W-1:0]     get_value1,
    input  logic [DATA_W-1:0]     get_value2,
    output logic [DATA_W-1:0]     val1,
    output logic [DATA_W-1:0]     val2,
    output logic                  ready1,
    output logic                  ready2,
    output logic [ROB_W-1:0]      dep1,
    output logic [ROB_W-1:0]      dep2
);

    logic [DATA_W-1:0] value_mem [REG_NUM];
    logic [ROB_W-1:0]  tag_mem   [REG_NUM];
    logic [REG_NUM-1:0] busy;

    logic do_commit;
    logic do_issue;

    assign do_commit = rdy && commit_valid && !is_x0(commit_rd);
    assign do_issue  = rdy && issue_valid && !is_x0(issue_rd) && !clear;

    // State update: commit writes first, then flush or issue override busy/tag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_mem[i] <= '0;
                tag_mem[i]   <= '0;
            end
            busy <= '0;
        end else begin
            if (do_commit) begin
                value_mem[commit_rd] <= commit_value;
                if (tag_mem[commit_rd] == commit_rob_id) begin
                    busy[commit_rd] <= 1'b0;
                end
            end
            if (rdy && clear) begin
                busy <= '0;
            end else if (do_issue) begin
                busy[issue_rd]    <= 1'b1;
                tag_mem[issue_rd] <= issue_rob_id;
            end
        end
    end

    assign get_rob_id1 = tag_mem[rs1];
    assign get_rob_id2 = tag_mem[rs2];

    reg_operand_resolve #(.ROB_W(ROB_W)) u_resolve1 (
        .rs            (rs1),
        .busy          (busy[rs1]),
        .tag           (tag_mem[rs1]),
        .reg_value     (value_mem[rs1]),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .get_ready     (get_ready1),
        .get_value     (get_value1),
        .val           (val1),
        .ready         (ready1),
        .dep           (dep1)
    );

    reg_operand_resolve #(.ROB_W(ROB_W)) u_resolve2 (
        .rs            (rs2),
        .busy          (busy[rs2]),
        .tag           (tag_mem[rs2]),
        .reg_value     (value_mem[rs2]),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_value  (commit_value),
        .get_ready     (get_ready2),
        .get_value     (get_value2),
        .val           (val2),
        .ready         (ready2),
        .dep           (dep2)
    );

endmodule
